// File: rtl/neuron_mac_accumulator_if.sv
// Term stream in, rescaled Q1.6 result out, for the neuron MAC stage.
// The driver side uses master; the accumulator uses slave.
interface neuron_mac_accumulator_if;
   logic       clear;
   logic       inValid;
   logic [7:0] xIn;
   logic [7:0] wIn;
   logic       lastIn;
   logic [7:0] dataOUT;
   logic       sign;
   logic       ovf;
   logic       outValid;
   logic       busy;

   modport master (
      output clear, inValid, xIn, wIn, lastIn,
      input  dataOUT, sign, ovf, outValid, busy
   );

   modport slave (
      input  clear, inValid, xIn, wIn, lastIn,
      output dataOUT, sign, ovf, outValid, busy
   );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// Three-stage signed Q1.6 multiply-accumulate over a frame, rescaled to Q1.6
// with sign and overflow flags for the downstream saturation stage.
module neuron_mac_accumulator #(
   parameter int MAX_TERMS = 64,
   parameter int ACC_W     = 16 + $clog2(MAX_TERMS)
) (
   input logic clk,
   input logic rst,
   neuron_mac_accumulator_if.slave bus
);

   localparam int CNT_W = $clog2(MAX_TERMS + 2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_TERMS + 1);
   localparam logic signed [ACC_W-1:0] RES_HI = ACC_W'(64);
   localparam logic signed [ACC_W-1:0] RES_LO = -ACC_W'(64);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t state;
   logic busyReg;

   logic signed [15:0] xExt;
   logic signed [15:0] wExt;
   logic signed [15:0] prodReg;
   logic v1, first1, last1;

   logic signed [ACC_W-1:0] prodExt;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0] termCnt;
   logic excess;
   logic v2, last2;

   logic signed [ACC_W-1:0] accSnap;
   logic exSnap;
   logic v3;

   logic signed [ACC_W-1:0] resFull;
   logic ovfNext;

   logic [7:0] dataReg;
   logic signReg, ovfReg, outValidReg;

   assign xExt = 16'($signed(bus.xIn));
   assign wExt = 16'($signed(bus.wIn));
   assign prodExt = ACC_W'(prodReg);

   // Frame tracking: a term seen in IDLE opens a new frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busyReg <= 1'b0;
      end else if (bus.clear) begin
         state   <= IDLE;
         busyReg <= 1'b0;
      end else if (bus.inValid) begin
         if (bus.lastIn) begin
            state   <= IDLE;
            busyReg <= 1'b0;
         end else begin
            state   <= ACCUM;
            busyReg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prodReg <= '0;
         v1      <= 1'b0;
         first1  <= 1'b0;
         last1   <= 1'b0;
      end else if (bus.clear) begin
         v1     <= 1'b0;
         first1 <= 1'b0;
         last1  <= 1'b0;
      end else begin
         v1     <= bus.inValid;
         first1 <= (state == IDLE);
         last1  <= bus.lastIn;
         if (bus.inValid)
            prodReg <= xExt * wExt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         termCnt <= '0;
         excess  <= 1'b0;
         v2      <= 1'b0;
         last2   <= 1'b0;
      end else if (bus.clear) begin
         acc     <= '0;
         termCnt <= '0;
         excess  <= 1'b0;
         v2      <= 1'b0;
         last2   <= 1'b0;
      end else begin
         v2    <= v1;
         last2 <= v1 && last1;
         if (v1) begin
            if (first1) begin
               acc     <= prodExt;
               termCnt <= CNT_W'(1);
               excess  <= 1'b0;
            end else begin
               acc <= acc + prodExt;
               if (termCnt != CNT_SAT)
                  termCnt <= termCnt + CNT_W'(1);
               // this term is number termCnt+1
               if (termCnt >= CNT_MAX)
                  excess <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accSnap <= '0;
         exSnap  <= 1'b0;
         v3      <= 1'b0;
      end else if (bus.clear) begin
         v3 <= 1'b0;
      end else begin
         v3 <= v2 && last2;
         if (v2 && last2) begin
            accSnap <= acc;
            exSnap  <= excess;
         end
      end
   end

   assign resFull = accSnap >>> 6;
   assign ovfNext = (resFull > RES_HI) || (resFull < RES_LO) || exSnap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dataReg     <= '0;
         signReg     <= 1'b0;
         ovfReg      <= 1'b0;
         outValidReg <= 1'b0;
      end else if (bus.clear) begin
         outValidReg <= 1'b0;
      end else begin
         outValidReg <= v3;
         if (v3) begin
            dataReg <= resFull[7:0];
            signReg <= accSnap[ACC_W-1];
            ovfReg  <= ovfNext;
         end
      end
   end

   assign bus.dataOUT  = dataReg;
   assign bus.sign     = signReg;
   assign bus.ovf      = ovfReg;
   assign bus.outValid = outValidReg;
   assign bus.busy     = busyReg;

endmodule

// File: doc/neuron_mac_accumulator.md
# neuron_mac_accumulator

Sequential multiply-accumulate stage that sits directly upstream of the saturation logic in the neuron datapath. It multiplies a stream of signed 8-bit Q1.6 inputs by signed 8-bit Q1.6 weights, accumulates the products over a frame at full precision, and rescales the sum back to Q1.6. It delivers the 8-bit result together with a sign bit and an overflow flag. The saturation stage then clamps the result to ±1.0 (0x40 / 0xC0) whenever the overflow flag is set.

## Interface
- MAX_TERMS, 64: maximum number of terms per frame.
- ACC_W, 22: accumulator width; equals 16 + clog2(MAX_TERMS).
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; flushes the pipeline and any frame in progress.
- inValid  input  1  the xIn/wIn/lastIn triple is sampled this cycle.
- xIn  input  8  signed Q1.6 activation.
- wIn  input  8  signed Q1.6 weight.
- lastIn  input  1  marks the final term of the frame (qualified by inValid).
- dataOUT  output  8  low 8 bits of the rescaled Q1.6 sum.
- sign  output  1  sign of the full-precision sum (1 = negative).
- ovf  output  1  the sum lies outside [-64, +64] in Q1.6 LSBs, or the term count exceeded MAX_TERMS.
- outValid  output  1  one-cycle pulse; the result outputs are new this cycle.
- busy  output  1  a frame is open; at least one term has been accepted and lastIn has not yet been seen.

## Operation
- **Frame FSM states.**
  - IDLE → ACCUM on inValid && !lastIn.
  - ACCUM → IDLE on inValid && lastIn.
  - IDLE with inValid && lastIn is a single-term frame; the FSM stays in IDLE.
  - clear forces IDLE from any state.
- **Tagging.** Each accepted term is tagged:
  - first = 1 when the FSM is in IDLE;
  - last = lastIn.
  - The tags travel down the pipeline with the data.
- **Stage 1.** prodReg = signed(xIn) × signed(wIn). This is 16-bit Q2.12 and exact.
- **Stage 2.** acc is ACC_W bits and signed.
  - acc = sext(prodReg) when first = 1.
  - acc = acc + sext(prodReg) otherwise.
  - No wrap can occur for up to MAX_TERMS terms.
- **Term counter.** termCnt is loaded with 1 on a first term and increments otherwise.
  - It saturates at MAX_TERMS+1.
  - Exceeding MAX_TERMS sets a sticky excess flag for the current frame.
  - The excess flag is cleared on the next first term.
- **Stage 3 (on a last-tagged term only).**
  - res = acc >>> 6, an arithmetic shift that truncates toward −∞.
  - dataOUT = res[7:0].
  - sign = acc[ACC_W-1].
  - ovf = (res > 64) || (res < −64) || excess.
  - outValid = 1.
- **Gaps.** inValid may drop for any number of cycles mid-frame; the accumulator holds.
- **Back-to-back frames.** A first term may follow a last term on the next cycle; no bubble is required.
- **Holding.** dataOUT, sign and ovf hold their value until the next outValid.
- **clear.**
  - Zeroes the pipeline valid bits, acc, termCnt and excess.
  - Suppresses any pending outValid.
  - Does not alter dataOUT, sign or ovf.
  - clear has priority over an inValid in the same cycle; that term is dropped.

## Timing
- **Reset values.** Reset is asynchronous.
  - dataOUT = 0x00, sign = 0, ovf = 0, outValid = 0, busy = 0.
  - FSM = IDLE; acc, prodReg, termCnt and excess = 0; all pipeline valid bits = 0.
- **Throughput.** One term per cycle, with no backpressure.
- **Latency.** A last term sampled at edge t produces outValid high for exactly the cycle after edge t+3, with results updated at edge t+3. This is 3 cycles.
- **busy timing.** busy rises the cycle after the first non-last term is sampled. It falls the cycle after lastIn is sampled.
- **Reset mid-frame.** All outputs return immediately to their reset values and the partial sum is discarded. The first term after reset release starts a new frame.

## Test plan
- **Single-term frame.** Reset, then one term x=0x40, w=0x20, lastIn=1.
  - Expect outValid 3 cycles later with dataOUT=0x20, sign=0, ovf=0.
- **Positive overflow.** Three terms of 0x40×0x40 back-to-back, the last tagged.
  - Sum = 12288 and res = 192.
  - Expect dataOUT=0xC0, sign=0, ovf=1.
- **Negative boundary and truncation.**
  - x=0xC0, w=0x40 alone: expect dataOUT=0xC0, sign=1, ovf=0 (exactly −64 is not an overflow).
  - x=0x01, w=0xFF alone: expect dataOUT=0xFF, sign=1, ovf=0.
- **Gaps and back-to-back.**
  - Frame A: 0x40×0x10, idle 2 cycles, then 0x40×0x10 tagged last.
  - Frame B follows immediately: 0x20×0x20, tagged last.
  - Expect A dataOUT=0x20 and B dataOUT=0x10, on outValid pulses exactly 1 cycle apart.
- **Term-count overflow.** MAX_TERMS+1 terms of 0x01×0x01.
  - Expect ovf=1 from the excess flag, dataOUT=0x01, sign=0.
- **Abort and reset.**
  - Assert clear mid-frame: expect no outValid, busy=0, and the next frame's result equal to a fresh computation.
  - Assert rst asynchronously mid-frame: expect all outputs 0 immediately.
